// File: rtl/mips16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips16_pkg                                                      |
// | Purpose  : Shared types and constants for the memory arbiter: FSM state    |
// |            encoding, requester port indices, round-robin pointer values    |
// |            and the default ISSUE timeout.                                  |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mips16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Requester port indices (bit positions in the rq_* vectors)
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] DATA  = 2'd1;
  localparam logic [1:0] DEBUG = 2'd2;

  // Round-robin pointer: remembers which of fetch/data was granted last
  localparam logic RR_FETCH = 1'b0;
  localparam logic RR_DATA  = 1'b1;

  localparam int TIMEOUT_DEFAULT = 15;

  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_pick3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : arb_pick3                                                       |
// | Purpose  : Combinational 3-way grant selection. Debug wins absolutely;     |
// |            fetch and data share round-robin using the last-served pointer. |
// | Ports    : rq_valid_i  [2:0] request vector (0 fetch, 1 data, 2 debug)     |
// |            rr_last_i        last fetch/data winner (RR_FETCH / RR_DATA)    |
// |            grant_o     [2:0] one-hot grant, zero when nothing requested    |
// |            grant_idx_o [1:0] index of the granted port                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module arb_pick3
  import mips16_pkg::*;
(
  input  logic [2:0] rq_valid_i,
  input  logic       rr_last_i,
  output logic [2:0] grant_o,
  output logic [1:0] grant_idx_o
);

  always_comb begin
    grant_idx_o = FETCH;
    if (rq_valid_i[DEBUG]) begin
      grant_idx_o = DEBUG;
    end else if (rq_valid_i[FETCH] && rq_valid_i[DATA]) begin
      // Tie: serve whichever of fetch/data did not win last time
      grant_idx_o = (rr_last_i == RR_DATA) ? FETCH : DATA;
    end else if (rq_valid_i[DATA]) begin
      grant_idx_o = DATA;
    end
    grant_o = (|rq_valid_i) ? idx_to_onehot(grant_idx_o) : 3'b000;
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                     |
// | Purpose  : Arbitrates fetch/data/debug requesters onto a single memory     |
// |            port. One access at a time: IDLE (accept) -> ISSUE (mem_req     |
// |            until ack or timeout) -> RESP (one-cycle response) -> IDLE.     |
// | Ports    : clk, reset (async, active-high)                                 |
// |            rq_valid/rq_we [2:0], rq_addr/rq_wdata packed per port          |
// |            rq_ready [2:0] accept pulse; rsp_valid [2:0] response pulse     |
// |            rsp_rdata, rsp_err  response data and timeout flag              |
// |            mem_req/mem_we/mem_addr/mem_wdata  memory request side          |
// |            mem_ack/mem_rdata  memory completion side                       |
// |            busy (not IDLE), grant_id (index of captured port)              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_arbiter
  import mips16_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            rq_valid,
  input  logic [2:0]            rq_we,
  input  logic [3*ADDR_W-1:0]   rq_addr,
  input  logic [3*DATA_W-1:0]   rq_wdata,
  output logic [2:0]            rq_ready,
  output logic [2:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic [1:0]            grant_id
);

  // Counter only needs to reach TIMEOUT-1: the timeout exit is taken on the
  // last allowed ISSUE cycle so mem_req is high for exactly TIMEOUT cycles.
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rr_last_q, rr_last_d;
  logic [1:0]          grant_id_q, grant_id_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [2:0]          w_grant;
  logic [1:0]          w_grant_idx;

  arb_pick3 u_pick (
    .rq_valid_i  (rq_valid),
    .rr_last_i   (rr_last_q),
    .grant_o     (w_grant),
    .grant_idx_o (w_grant_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rr_last_q  <= RR_DATA;
      grant_id_q <= FETCH;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_last_q  <= rr_last_d;
      grant_id_q <= grant_id_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_last_d  = rr_last_q;
    grant_id_d = grant_id_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    rq_ready   = 3'b000;
    rsp_valid  = 3'b000;
    rsp_rdata  = '0;
    rsp_err    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (|rq_valid) begin
          // Gate with reset so no accept pulse escapes while reset is held
          rq_ready   = w_grant & {3{~reset}};
          grant_id_d = w_grant_idx;
          we_d       = |(rq_we & w_grant);
          for (int i = 0; i < 3; i++) begin
            if (w_grant[i]) begin
              addr_d  = rq_addr[i*ADDR_W +: ADDR_W];
              wdata_d = rq_wdata[i*DATA_W +: DATA_W];
            end
          end
          // Debug grants must not disturb fetch/data fairness
          if (w_grant_idx != DEBUG) begin
            rr_last_d = (w_grant_idx == DATA) ? RR_DATA : RR_FETCH;
          end
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ack) begin
          rdata_d = we_q ? '0 : mem_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        rsp_valid = idx_to_onehot(grant_id_q);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                                  |
// | Purpose  : Self-checking bench for mem_arbiter: vector table, directed     |
// |            corner sequences and randomized traffic against a              |
// |            transaction-level reference model.                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int TO     = 15;

  logic                clk = 1'b0;
  logic                reset;
  logic [2:0]          rq_valid;
  logic [2:0]          rq_we;
  logic [3*ADDR_W-1:0] rq_addr;
  logic [3*DATA_W-1:0] rq_wdata;
  logic [2:0]          rq_ready;
  logic [2:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;
  logic                busy;
  logic [1:0]          grant_id;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .rq_valid(rq_valid), .rq_we(rq_we), .rq_addr(rq_addr), .rq_wdata(rq_wdata),
    .rq_ready(rq_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-port payload the requesters present
  logic              r_we    [3];
  logic [ADDR_W-1:0] r_addr  [3];
  logic [DATA_W-1:0] r_wdata [3];

  typedef struct {
    logic [2:0] valid;
    logic       we;
    int         wt;         // ISSUE cycles before ack; >= TO means never
    logic [2:0] exp_ready;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic load_payload();
    rq_we    = {r_we[2], r_we[1], r_we[0]};
    rq_addr  = {r_addr[2], r_addr[1], r_addr[0]};
    rq_wdata = {r_wdata[2], r_wdata[1], r_wdata[0]};
  endtask

  // Reference arbitration: debug first, otherwise fetch/data alternate on ties
  function automatic logic [2:0] model_pick(input logic [2:0] m, input logic last_was_data);
    if (m[2]) return 3'b100;
    if (m[1:0] == 2'b11) return last_was_data ? 3'b001 : 3'b010;
    return m;
  endfunction

  // One complete access: accept cycle, ISSUE cycles, one RESP cycle.
  task automatic run_txn(input logic [2:0] mask, input logic [2:0] exp_rdy, input int wt,
                         input logic [DATA_W-1:0] rd, input string tag);
    int idx;
    bit acked;
    int len;
    int nreq;
    idx   = exp_rdy[2] ? 2 : (exp_rdy[1] ? 1 : 0);
    acked = (wt < TO);
    len   = acked ? wt + 1 : TO;

    @(negedge clk);
    rq_valid  = mask;
    load_payload();
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = DATA_W'($urandom);
    #1;
    chk({tag, " ready"}, 64'(rq_ready), 64'(exp_rdy));
    chk({tag, " idle_busy"}, 64'(busy), 64'd0);
    chk({tag, " idle_req"}, 64'(mem_req), 64'd0);

    nreq = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      rq_valid  = mask & ~exp_rdy;
      mem_ack   = acked && (k == wt);
      mem_rdata = (acked && (k == wt)) ? rd : DATA_W'($urandom);
      #1;
      if (mem_req === 1'b1) nreq++;
      chk({tag, " issue_req"}, 64'(mem_req), 64'd1);
      chk({tag, " issue_we"}, 64'(mem_we), 64'(r_we[idx]));
      chk({tag, " issue_addr"}, 64'(mem_addr), 64'(r_addr[idx]));
      chk({tag, " issue_wdata"}, 64'(mem_wdata), 64'(r_wdata[idx]));
      chk({tag, " issue_ready"}, 64'(rq_ready), 64'd0);
      chk({tag, " issue_rsp"}, 64'(rsp_valid), 64'd0);
      chk({tag, " issue_gid"}, 64'(grant_id), 64'(idx));
    end
    chk({tag, " req_cycles"}, 64'(nreq), 64'(len));

    @(negedge clk);
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = DATA_W'($urandom);
    #1;
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(exp_rdy));
    chk({tag, " rsp_rdata"}, 64'(rsp_rdata), (acked && !r_we[idx]) ? 64'(rd) : 64'd0);
    chk({tag, " rsp_err"}, 64'(rsp_err), 64'(!acked));
    chk({tag, " rsp_req"}, 64'(mem_req), 64'd0);
    chk({tag, " rsp_ready"}, 64'(rq_ready), 64'd0);
    mem_ack = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       last_data;
    logic [2:0] vmask;
    logic [2:0] newb;
    logic [2:0] exp;
    int         wt;

    // Contention pattern with a debug request mid-run; expectations hand-derived
    // starting from the reset pointer (fetch wins the first tie).
    tbl[0]  = '{3'b011, 1'b0, 0,  3'b001};
    tbl[1]  = '{3'b011, 1'b1, 1,  3'b010};
    tbl[2]  = '{3'b011, 1'b0, 0,  3'b001};
    tbl[3]  = '{3'b111, 1'b0, 2,  3'b100};
    tbl[4]  = '{3'b011, 1'b1, 0,  3'b010};
    tbl[5]  = '{3'b011, 1'b0, 0,  3'b001};
    tbl[6]  = '{3'b010, 1'b0, 0,  3'b010};
    tbl[7]  = '{3'b010, 1'b1, 0,  3'b010};
    tbl[8]  = '{3'b011, 1'b0, 3,  3'b001};
    tbl[9]  = '{3'b101, 1'b0, 0,  3'b100};
    tbl[10] = '{3'b001, 1'b0, TO, 3'b001};
    tbl[11] = '{3'b011, 1'b0, 0,  3'b010};

    for (int p = 0; p < 3; p++) begin
      r_we[p] = 1'b0; r_addr[p] = '0; r_wdata[p] = '0;
    end

    // Reset state
    reset = 1'b1; rq_valid = 3'b111; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    load_payload();
    repeat (2) @(negedge clk);
    #1;
    chk("reset rq_ready", 64'(rq_ready), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset mem_req", 64'(mem_req), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset grant_id", 64'(grant_id), 64'd0);
    chk("reset rsp_err", 64'(rsp_err), 64'd0);
    chk("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset mem_addr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0; rq_valid = 3'b000; mem_ack = 1'b0;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      for (int p = 0; p < 3; p++) begin
        r_we[p]    = tbl[i].we;
        r_addr[p]  = ADDR_W'(32'h0100 * (p + 1) + i);
        r_wdata[p] = DATA_W'($urandom);
      end
      run_txn(tbl[i].valid, tbl[i].exp_ready, tbl[i].wt, DATA_W'(32'h5A00 + i),
              $sformatf("vec%0d", i));
    end

    // Single read from fetch
    r_we[0] = 1'b0; r_addr[0] = 16'h0010; r_wdata[0] = 16'h0000;
    run_txn(3'b001, 3'b001, 0, 16'h1234, "single_read");

    // Timeout with no ack at all
    r_addr[0] = 16'h0020;
    run_txn(3'b001, 3'b001, TO + 5, 16'h9999, "timeout");

    // Write on data port with delayed ack: mem_req held three cycles
    r_we[1] = 1'b1; r_addr[1] = 16'h0040; r_wdata[1] = 16'hBEEF;
    run_txn(3'b010, 3'b010, 2, 16'hAAAA, "write");

    // Stray acks in IDLE change nothing
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rq_valid = 3'b000; mem_ack = 1'b1; mem_rdata = DATA_W'($urandom);
      #1;
      chk("stray busy", 64'(busy), 64'd0);
      chk("stray mem_req", 64'(mem_req), 64'd0);
      chk("stray rsp_valid", 64'(rsp_valid), 64'd0);
      chk("stray rq_ready", 64'(rq_ready), 64'd0);
      chk("stray rsp_err", 64'(rsp_err), 64'd0);
      chk("stray grant_id", 64'(grant_id), 64'd1);
    end
    mem_ack = 1'b0;

    // Reset while ISSUE is in flight (fetch granted last, so only reset
    // can make fetch win the following tie)
    r_we[0] = 1'b0; r_addr[0] = 16'h0200;
    @(negedge clk);
    rq_valid = 3'b001; load_payload();
    #1;
    chk("rstiss ready", 64'(rq_ready), 64'd1);
    @(negedge clk);
    rq_valid = 3'b000;
    #1;
    chk("rstiss pre_req", 64'(mem_req), 64'd1);
    #1;
    reset = 1'b1; rq_valid = 3'b011; mem_ack = 1'b1;
    #1;
    chk("rstiss mem_req", 64'(mem_req), 64'd0);
    chk("rstiss busy", 64'(busy), 64'd0);
    chk("rstiss grant_id", 64'(grant_id), 64'd0);
    chk("rstiss rq_ready", 64'(rq_ready), 64'd0);
    chk("rstiss rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("rstiss held_req", 64'(mem_req), 64'd0);
    chk("rstiss held_ready", 64'(rq_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0; rq_valid = 3'b000; mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_ack = 1'b1;
      #1;
      chk("rstiss no_rsp", 64'(rsp_valid), 64'd0);
      chk("rstiss idle", 64'(busy), 64'd0);
    end
    mem_ack = 1'b0;
    run_txn(3'b011, 3'b001, 0, 16'h7777, "post_reset");

    // Randomized traffic against the transaction-level model
    last_data = 1'b0;
    vmask     = 3'b000;
    for (int t = 0; t < 60; t++) begin
      newb = 3'($urandom_range(0, 7));
      if ((vmask | newb) == 3'b000) newb = 3'b001 << $urandom_range(0, 2);
      for (int p = 0; p < 3; p++) begin
        if (newb[p] && !vmask[p]) begin
          r_we[p]    = 1'($urandom_range(0, 1));
          r_addr[p]  = ADDR_W'($urandom);
          r_wdata[p] = DATA_W'($urandom);
        end
      end
      vmask = vmask | newb;
      exp   = model_pick(vmask, last_data);
      if (exp == 3'b001) last_data = 1'b0;
      if (exp == 3'b010) last_data = 1'b1;
      wt = ($urandom_range(0, 4) != 0) ? int'($urandom_range(0, 3))
                                       : int'($urandom_range(0, TO + 2));
      run_txn(vmask, exp, wt, DATA_W'($urandom), $sformatf("rnd%0d", t));
      vmask = vmask & ~exp;
    end
    rq_valid = 3'b000;

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum ISSUE cycles allowed without mem_ack.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rq_valid  input  3  request valid per port: bit0 fetch, bit1 data, bit2 debug.
REQ-007 SHALL have port rq_we  input  3  per-port write enable (1 = write).
REQ-008 SHALL have port rq_addr  input  3*ADDR_W  per-port address, port n at bits [n*ADDR_W +: ADDR_W].
REQ-009 SHALL have port rq_wdata  input  3*DATA_W  per-port write data, same packing.
REQ-010 SHALL have port rq_ready  output  3  one-hot one-cycle accept pulse.
REQ-011 SHALL have port rsp_valid  output  3  one-hot one-cycle response pulse to the granted port.
REQ-012 SHALL have port rsp_rdata  output  DATA_W  shared read data, valid with rsp_valid.
REQ-013 SHALL have port rsp_err  output  1  timeout flag, valid with rsp_valid.
REQ-014 SHALL have ports mem_req/mem_we  output  1 each  memory request and write strobe.
REQ-015 SHALL have ports mem_addr/mem_wdata  output  ADDR_W/DATA_W  memory address and write data.
REQ-016 SHALL have ports mem_ack/mem_rdata  input  1/DATA_W  memory completion and read data.
REQ-017 SHALL have ports busy  output  1 (state != IDLE) and grant_id  output  2 (captured port index).

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE; no other states.
REQ-019 In IDLE with any rq_valid set, SHALL grant one port, pulse its rq_ready, capture we/addr/wdata/index into registers, and enter ISSUE next cycle.
REQ-020 Priority SHALL be: debug absolutely over fetch/data; fetch vs data round-robin via 1-bit rr_last pointer.
REQ-021 rr_last SHALL update only on fetch/data grants; debug grants SHALL leave it unchanged; rr_last resets to data (fetch wins first tie).
REQ-022 In ISSUE, mem_req SHALL be 1 and mem_we/addr/wdata SHALL drive captured values, constant until exit.
REQ-023 In ISSUE, mem_ack=1 SHALL move to RESP, registering mem_rdata (reads) or 0 (writes), rsp_err=0.
REQ-024 ISSUE SHALL count cycles from 0; when count reaches TIMEOUT without ack, SHALL move to RESP with rdata=0, rsp_err=1.
REQ-025 In RESP, SHALL pulse rsp_valid[grant_id] for exactly one cycle, then return to IDLE.
REQ-026 Minimum latency SHALL be: accept cycle N, mem_req N+1, rsp_valid N+2 when acked at N+1.
REQ-027 mem_ack in IDLE or RESP SHALL be ignored.
REQ-028 Requesters SHALL hold rq_valid and payload until rq_ready; arbiter SHALL not accept in ISSUE or RESP.
REQ-029 rq_ready, rsp_valid, mem_req SHALL be 0 outside their respective states; at most one bit of rq_ready/rsp_valid set.
REQ-030 Back-to-back: new grant SHALL be possible in the IDLE cycle immediately after RESP (throughput 1 access / 3 cycles minimum).

Reset
REQ-031 reset SHALL force state IDLE, counter 0, rr_last=data, grant_id 0, all outputs 0, immediately and asynchronously.
REQ-032 Reset during ISSUE SHALL drop mem_req at once; the in-flight access SHALL produce no rsp_valid.
REQ-033 First grant SHALL occur no earlier than the first clk edge after reset deasserts.

Structure
REQ-034 State encoding, port index constants (FETCH=0, DATA=1, DEBUG=2) and TIMEOUT default SHALL live in shared package mips16_pkg.
REQ-035 Grant selection SHALL be a combinational sub-module arb_pick3 (rq_valid, rr_last -> one-hot grant, index); FSM, counter and capture registers stay in mem_arbiter.

Verification
REQ-036 Single read: fetch addr 0x0010, mem_ack one cycle after mem_req, mem_rdata 0x1234 -> rsp_valid=001 two cycles after rq_ready, rsp_rdata 0x1234, err 0.
REQ-037 Contention: fetch and data held valid continuously -> grants alternate F,D,F,D; debug asserted mid-run -> served next IDLE, alternation resumes unchanged.
REQ-038 Write: data port we=1, addr 0x0040, wdata 0xBEEF, ack delayed 3 cycles -> mem_req held 3 cycles with stable payload, rsp_valid=010, rdata 0.
REQ-039 Timeout: TIMEOUT=15, mem_ack never asserted -> mem_req high exactly 15 cycles, then rsp_valid with err=1, rdata 0.
REQ-040 Reset in ISSUE: assert reset while mem_req=1 -> mem_req 0 same cycle, no rsp_valid, first post-reset grant to fetch on tie.
REQ-041 Stray ack: mem_ack pulsed in IDLE with no requests -> no state change, all outputs 0.
